// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and types for the AES-128 key scheduler.
//   NR                : number of AES-128 rounds (10)
//   RCON[1:10]        : round constants
//   SBOX[0:255]       : forward AES S-box
//   key_sched_state_t : scheduler FSM states
//   rcon_of()         : round-constant lookup, 0 outside 1..10
package aes_pkg;

    localparam int unsigned NR = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } key_sched_state_t;

    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        logic [7:0] v;
        v = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            if (rnd == 4'(i)) v = RCON[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational SubWord, four parallel S-box lookups.
//   i_word [31:0] : input word
//   o_word [31:0] : byte-wise S-box substitution of i_word
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                     SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES-128 key scheduler feeding the round datapath.
// Registers the cipher key as the round-0 key and produces round keys 1..10
// one per En_Func strobe.
//   CLK, rst_n (async, active-low)
//   Valid, Key_in[127:0] : load a key and (re)start the schedule
//   En_Func              : round-advance strobe shared with the round datapath
//   key_rnd0[127:0]      : registered cipher key
//   key_rndn[127:0]      : round key for round Rnd_cnt
//   Rf_valid             : one-cycle start pulse to the round datapath
//   Rnd_cnt[3:0]         : round index of key_rndn (0..10)
//   Busy                 : schedule in progress (LOAD/RUN)
//   Key_done             : one-cycle pulse when Rnd_cnt reaches 10
//   Err                  : sticky protocol error, only with AES_KEY_SCHED_ERR_EN
module aes_key_sched
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         Valid,
    input  logic [127:0] Key_in,
    input  logic         En_Func,
    output logic [127:0] key_rnd0,
    output logic [127:0] key_rndn,
    output logic         Rf_valid,
    output logic [3:0]   Rnd_cnt,
    output logic         Busy,
    output logic         Key_done
`ifdef AES_KEY_SCHED_ERR_EN
    ,
    output logic         Err
`endif
);

    key_sched_state_t r_state, w_state_nxt;

    logic [127:0] r_key;
    logic [127:0] r_rk;
    logic [3:0]   r_cnt;
    logic         r_rf_valid;
    logic         r_key_done;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [7:0]   w_rc;
    logic [127:0] w_rk_next;
    logic         w_last_step;

    // In LOAD the count is 0, so cnt+1 also yields RCON[1] there.
    assign w_rc = rcon_of(r_cnt + 4'd1);

    assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    aes_sub_word u_sub_word (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_t  = w_sub ^ {w_rc, 24'h0};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;
    assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

    assign w_last_step = (r_state == RUN) && En_Func && (r_cnt == 4'(NR - 1));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (Valid) begin
            w_state_nxt = LOAD;
        end else begin
            case (r_state)
                LOAD:    w_state_nxt = RUN;
                RUN:     if (w_last_step) w_state_nxt = DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_key      <= '0;
            r_rk       <= '0;
            r_cnt      <= '0;
            r_rf_valid <= 1'b0;
            r_key_done <= 1'b0;
        end else if (Valid) begin
            r_key      <= Key_in;
            r_rk       <= Key_in;
            r_cnt      <= '0;
            r_rf_valid <= 1'b1;
            r_key_done <= 1'b0;
        end else begin
            r_rf_valid <= 1'b0;
            r_key_done <= w_last_step;
            case (r_state)
                LOAD: begin
                    r_rk  <= w_rk_next;
                    r_cnt <= 4'd1;
                end
                RUN: begin
                    if (En_Func) begin
                        r_rk  <= w_rk_next;
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AES_KEY_SCHED_ERR_EN
    logic r_err;

    // A clearing restart outranks a simultaneous En_Func in IDLE.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (Valid && (r_state == IDLE || r_state == DONE)) begin
            r_err <= 1'b0;
        end else if ((r_state == IDLE && En_Func) || (r_state == RUN && Valid)) begin
            r_err <= 1'b1;
        end
    end

    assign Err = r_err;
`endif

    assign key_rnd0 = r_key;
    assign key_rndn = r_rk;
    assign Rnd_cnt  = r_cnt;
    assign Rf_valid = r_rf_valid;
    assign Key_done = r_key_done;
    assign Busy     = (r_state == LOAD) || (r_state == RUN);

endmodule

// File: tb/tb_aes_key_sched.sv
module tb_aes_key_sched;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic         Valid;
    logic [127:0] Key_in;
    logic         En_Func;
    logic [127:0] key_rnd0;
    logic [127:0] key_rndn;
    logic         Rf_valid;
    logic [3:0]   Rnd_cnt;
    logic         Busy;
    logic         Key_done;
`ifdef AES_KEY_SCHED_ERR_EN
    logic         Err;
`endif

    always #5 CLK = ~CLK;

    aes_key_sched dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .Valid    (Valid),
        .Key_in   (Key_in),
        .En_Func  (En_Func),
        .key_rnd0 (key_rnd0),
        .key_rndn (key_rndn),
        .Rf_valid (Rf_valid),
        .Rnd_cnt  (Rnd_cnt),
        .Busy     (Busy),
        .Key_done (Key_done)
`ifdef AES_KEY_SCHED_ERR_EN
        ,
        .Err      (Err)
`endif
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    // Reference model: S-box derived from GF(2^8) inverse + affine map,
    // key expansion over a 44-word array as in FIPS-197.
    logic [7:0]   sb [256];
    logic [127:0] rk_m [11];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_keys(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives Valid for one edge; on return the DUT is in its first cycle after the load.
    task automatic load(input logic [127:0] key);
        Valid  = 1'b1;
        Key_in = key;
        tick();
        Valid  = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, ".rnd0"}, key_rnd0, '0);
        chk({nm, ".rndn"}, key_rndn, '0);
        chk({nm, ".cnt"},  128'(Rnd_cnt), '0);
        chk({nm, ".rfv"},  128'(Rf_valid), '0);
        chk({nm, ".busy"}, 128'(Busy), '0);
        chk({nm, ".done"}, 128'(Key_done), '0);
`ifdef AES_KEY_SCHED_ERR_EN
        chk({nm, ".err"},  128'(Err), '0);
`endif
    endtask

    typedef struct {
        logic [127:0] key;
        int unsigned  rnd;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int unsigned done_cnt;
        int unsigned budget;
        int unsigned exp_cnt;
        logic        exp_done;
        logic        en;
        logic [127:0] k;

        tbl[0] = '{key: FIPS_KEY, rnd: 0,  exp: FIPS_KEY};
        tbl[1] = '{key: FIPS_KEY, rnd: 1,  exp: FIPS_R1};
        tbl[2] = '{key: FIPS_KEY, rnd: 10, exp: FIPS_R10};
        tbl[3] = '{key: '0,       rnd: 1,  exp: ZERO_R1};
        tbl[4] = '{key: '0,       rnd: 0,  exp: '0};

        build_sbox();

        rst_n = 1'b0; Valid = 1'b0; En_Func = 1'b0; Key_in = '0;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check_all_zero("idle");

        // model sanity against published vectors
        model_keys(FIPS_KEY);
        chk("model.r1", rk_m[1], FIPS_R1);
        chk("model.r10", rk_m[10], FIPS_R10);

        // table-driven: run to a target round with En_Func high
        for (int v = 0; v < 5; v++) begin
            En_Func = 1'b1;
            load(tbl[v].key);
            budget = 0;
            while (Rnd_cnt != 4'(tbl[v].rnd) && budget < 20) begin
                tick();
                budget++;
            end
            chk($sformatf("tbl%0d.cnt", v), 128'(Rnd_cnt), 128'(tbl[v].rnd));
            chk($sformatf("tbl%0d.key", v), key_rndn, tbl[v].exp);
        end

        // FIPS full run: cycle-accurate timing, single Key_done, hold in DONE
        En_Func = 1'b1;
        load(FIPS_KEY);
        chk("fips.c1.rfv",  128'(Rf_valid), 128'(1));
        chk("fips.c1.rnd0", key_rnd0, FIPS_KEY);
        chk("fips.c1.rndn", key_rndn, FIPS_KEY);
        chk("fips.c1.busy", 128'(Busy), 128'(1));
        tick();
        chk("fips.c2.rndn", key_rndn, FIPS_R1);
        chk("fips.c2.cnt",  128'(Rnd_cnt), 128'(1));
        chk("fips.c2.rfv",  128'(Rf_valid), 128'(0));
        done_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            tick();
            if (Key_done) done_cnt++;
        end
        chk("fips.lat.cnt", 128'(Rnd_cnt), 128'(10));
        chk("fips.lat.key", key_rndn, FIPS_R10);
        chk("fips.lat.done", 128'(Key_done), 128'(1));
        chk("fips.lat.busy", 128'(Busy), 128'(0));
        for (int c = 0; c < 20; c++) begin
            tick();
            if (Key_done) done_cnt++;
        end
        chk("fips.done_once", 128'(done_cnt), 128'(1));
        chk("fips.hold.key", key_rndn, FIPS_R10);
        chk("fips.hold.cnt", 128'(Rnd_cnt), 128'(10));

        // En_Func toggling 1/0 during RUN
        En_Func = 1'b0;
        load(FIPS_KEY);
        tick();
        exp_cnt = 1;
        for (int c = 0; c < 18; c++) begin
            En_Func = (c % 2 == 0);
            tick();
            if (c % 2 == 0) exp_cnt++;
            chk($sformatf("tog%0d.cnt", c), 128'(Rnd_cnt), 128'(exp_cnt));
        end
        En_Func = 1'b0;
        chk("tog.final", key_rndn, FIPS_R10);

        // abort at round 5 with an all-zero key
        En_Func = 1'b1;
        load(FIPS_KEY);
        budget = 0;
        while (Rnd_cnt != 4'd5 && budget < 20) begin
            tick();
            budget++;
        end
        chk("abort.reach5", 128'(Rnd_cnt), 128'(5));
        load('0);
        chk("abort.cnt", 128'(Rnd_cnt), 128'(0));
        chk("abort.rfv", 128'(Rf_valid), 128'(1));
        chk("abort.rnd0", key_rnd0, '0);
`ifdef AES_KEY_SCHED_ERR_EN
        chk("abort.err", 128'(Err), 128'(1));
`endif
        tick();
        chk("abort.r1", key_rndn, ZERO_R1);

        // async reset at round 3
        load(FIPS_KEY);
        budget = 0;
        while (Rnd_cnt != 4'd3 && budget < 20) begin
            tick();
            budget++;
        end
        chk("rst.reach3", 128'(Rnd_cnt), 128'(3));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst.async");
        tick();
        rst_n = 1'b1;
        En_Func = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("rst.ign.cnt",  128'(Rnd_cnt), 128'(0));
        chk("rst.ign.busy", 128'(Busy), 128'(0));
        chk("rst.ign.rndn", key_rndn, '0);

        // Valid + En_Func together in DONE: restart wins
        load(FIPS_KEY);
        for (int c = 0; c < 12; c++) tick();
        chk("done.reach", 128'(Rnd_cnt), 128'(10));
        load(FIPS_R1);
        chk("done.restart.cnt", 128'(Rnd_cnt), 128'(0));
        chk("done.restart.rfv", 128'(Rf_valid), 128'(1));
        chk("done.restart.rnd0", key_rnd0, FIPS_R1);

        // randomized keys and En_Func patterns against the model
        for (int r = 0; r < 20; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_keys(k);
            En_Func = 1'($urandom);
            load(k);
            chk($sformatf("rnd%0d.c1", r), key_rndn, k);
            En_Func = 1'($urandom);
            tick();
            exp_cnt = 1;
            chk($sformatf("rnd%0d.c2", r), key_rndn, rk_m[1]);
            for (int c = 0; c < 25; c++) begin
                en = 1'($urandom);
                En_Func = en;
                tick();
                exp_done = 1'b0;
                if (en && exp_cnt < 10) begin
                    exp_cnt++;
                    exp_done = (exp_cnt == 10);
                end
                chk($sformatf("rnd%0d.%0d.cnt", r, c),  128'(Rnd_cnt), 128'(exp_cnt));
                chk($sformatf("rnd%0d.%0d.key", r, c),  key_rndn, rk_m[exp_cnt]);
                chk($sformatf("rnd%0d.%0d.done", r, c), 128'(Key_done), 128'(exp_done));
                chk($sformatf("rnd%0d.%0d.busy", r, c), 128'(Busy), 128'(exp_cnt < 10));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
